// File: rtl/lsu_unit_if.sv
// ============================================================================
// Module      : lsu_unit_if
// Description : Bundles the issue, writeback, memory and exception signals of
//               the load/store unit. The slave modport is the LSU's view and
//               the master modport is the view of the surrounding pipeline and
//               memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_unit_if #(
    parameter int XLEN = 32
);
    // Issue side
    logic                issue_valid;
    logic                issue_ready;
    logic [3:0]          op;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [11:0]         imm;
    logic [4:0]          rd;
    // Writeback side
    logic                wb_en;
    logic [4:0]          wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                wb_pending;
    // Data-memory port
    logic                mem_req;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic [XLEN-1:0]     mem_rdata;
    logic                mem_ack;
    // Exceptions
    logic                exc_valid;
    logic [3:0]          exc_cause;
    logic [XLEN-1:0]     exc_addr;

    modport slave (
        input  issue_valid, op, rs1_data, rs2_data, imm, rd, mem_rdata, mem_ack,
        output issue_ready, wb_en, wb_rd, wb_data, wb_pending,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output exc_valid, exc_cause, exc_addr
    );

    modport master (
        output issue_valid, op, rs1_data, rs2_data, imm, rd, mem_rdata, mem_ack,
        input  issue_ready, wb_en, wb_rd, wb_data, wb_pending,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  exc_valid, exc_cause, exc_addr
    );
endinterface

`default_nettype wire

// File: rtl/lsu_unit.sv
// ============================================================================
// Module      : lsu_unit
// Description : Execute-stage load/store unit. Accepts one op per issue
//               handshake, forms the effective address, issues a word-aligned
//               memory request with byte strobes, and returns sign/zero
//               extended load data to writeback. Raises illegal-op and
//               misalignment exceptions.
//               Optional macro LSU_TIMEOUT_EN adds a memory-ack watchdog that
//               raises an access fault after MEM_TIMEOUT cycles in ACCESS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_unit #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  wire logic  clk,
    input  wire logic  rst,      // asynchronous, active-low
    lsu_unit_if.slave  bus
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_EXC    = 2'd3;

    // Reject unsupported configurations at elaboration
    if (!((XLEN == 32) || (XLEN == 64)) || (MEM_TIMEOUT < 1)) begin : g_bad_param
        $error("lsu_unit: XLEN must be 32 or 64 and MEM_TIMEOUT at least 1");
    end

    logic [1:0]      state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] ea_q, ea_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            pend_q, pend_d;
    logic [3:0]      cause_q, cause_d;

    logic [XLEN-1:0] ea;
    logic            accept;
    logic            illegal;
    logic            misaligned;
    logic            timeout;
    logic [XLEN-1:0] rsh;
    logic [XLEN-1:0] load_ext;
    logic [7:0]      strb_base8;

    wire logic [OFF_W-1:0] off_q = ea_q[OFF_W-1:0];
    wire logic             store_q = op_q[3];

`ifdef LSU_TIMEOUT_EN
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    logic [TO_W-1:0] cnt_q, cnt_d;
`endif

    // Effective address: base plus sign-extended 12-bit offset
    assign ea     = bus.rs1_data + {{(XLEN-12){bus.imm[11]}}, bus.imm};
    assign accept = bus.issue_valid && (state_q == S_IDLE);

    // Decode the presented op for illegal encodings and misalignment
    always_comb begin
        illegal = ((bus.op[1:0] == 2'd3) && (XLEN == 32))
               || ((XLEN == 32) && !bus.op[3] && bus.op[2] && (bus.op[1:0] == 2'd2))
               || (bus.op == 4'b0111)
               || (bus.op[3] && bus.op[2]);
        case (bus.op[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = ea[0];
            2'd2:    misaligned = |ea[1:0];
            default: misaligned = |ea[2:0];
        endcase
    end

    // Watchdog expiry: ack arriving on the same cycle takes precedence
`ifdef LSU_TIMEOUT_EN
    assign timeout = (state_q == S_ACCESS) && !bus.mem_ack
                  && (cnt_q == TO_W'(MEM_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // Lane-shift read data down and extend it to XLEN by size and signedness
    always_comb begin
        rsh      = bus.mem_rdata >> {off_q, 3'b000};
        load_ext = rsh;
        case (op_q[1:0])
            2'd0: begin
                load_ext       = {XLEN{!op_q[2] && rsh[7]}};
                load_ext[7:0]  = rsh[7:0];
            end
            2'd1: begin
                load_ext       = {XLEN{!op_q[2] && rsh[15]}};
                load_ext[15:0] = rsh[15:0];
            end
            2'd2: begin
                load_ext       = {XLEN{!op_q[2] && rsh[31]}};
                load_ext[31:0] = rsh[31:0];
            end
            default: load_ext = rsh;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (illegal || misaligned) ? S_EXC : S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.mem_ack) state_d = S_DONE;
                else if (timeout) state_d = S_EXC;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latch op on accept, load data on ack
    always_comb begin
        op_d      = op_q;
        ea_d      = ea_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        pend_d    = pend_q;
        cause_d   = cause_q;
        if (accept) begin
            op_d    = bus.op;
            ea_d    = ea;
            wdata_d = bus.rs2_data;
            if (!bus.op[3]) rd_d = bus.rd;
            pend_d  = !bus.op[3] && !illegal && !misaligned;
            if (illegal)         cause_d = 4'd2;
            else if (misaligned) cause_d = bus.op[3] ? 4'd6 : 4'd4;
        end else if ((state_q == S_ACCESS) && bus.mem_ack) begin
            if (!store_q) wb_data_d = load_ext;
            pend_d = 1'b0;
        end else if (timeout) begin
            cause_d = store_q ? 4'd7 : 4'd5;
            pend_d  = 1'b0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Cycles spent in ACCESS, cleared on entry
    always_comb begin
        cnt_d = cnt_q;
        if (accept)                     cnt_d = '0;
        else if (state_q == S_ACCESS)   cnt_d = cnt_q + TO_W'(1);
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            ea_q      <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            pend_q    <= 1'b0;
            cause_q   <= '0;
        end else begin
            op_q      <= op_d;
            ea_q      <= ea_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            pend_q    <= pend_d;
            cause_q   <= cause_d;
        end
    end

    // Strobe pattern for the access size before lane shifting
    always_comb begin
        case (op_q[1:0])
            2'd0:    strb_base8 = 8'h01;
            2'd1:    strb_base8 = 8'h03;
            2'd2:    strb_base8 = 8'h0F;
            default: strb_base8 = 8'hFF;
        endcase
    end

    // Outputs decoded from state; memory fields are held stable in ACCESS
    always_comb begin
        bus.issue_ready = (state_q == S_IDLE);
        bus.mem_req     = (state_q == S_ACCESS);
        bus.mem_we      = (state_q == S_ACCESS) && store_q;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_wstrb   = '0;
        bus.wb_en       = (state_q == S_DONE) && !store_q;
        bus.wb_rd       = rd_q;
        bus.wb_data     = wb_data_q;
        bus.wb_pending  = pend_q;
        bus.exc_valid   = (state_q == S_EXC);
        bus.exc_cause   = '0;
        bus.exc_addr    = '0;
        if (state_q == S_ACCESS) begin
            bus.mem_addr = {ea_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            if (store_q) begin
                bus.mem_wdata = wdata_q << {off_q, 3'b000};
                bus.mem_wstrb = strb_base8[STRB_W-1:0] << off_q;
            end
        end
        if (state_q == S_EXC) begin
            bus.exc_cause = cause_q;
            bus.exc_addr  = ea_q;
        end
    end

endmodule

`default_nettype wire
